// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// Holds on ex_stall, bubbles on flush/hazard/invalid decode, counts load-use bubbles.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic        id_funct30,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ALUSrc,
  input  logic        Branch,
  input  logic [1:0]  ALUop,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct30,
  output logic        ex_RegWrite,
  output logic        ex_MemtoReg,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_ALUSrc,
  output logic        ex_Branch,
  output logic [1:0]  ex_ALUop,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        load_use_stall,
  output logic [15:0] hazard_cnt
);

  logic load_bubble;
  logic load_instr;
  logic count_hazard;

  // rs2 is compared even for instructions that do not read it; a spurious stall is safe
  assign load_use_stall = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign pc_write   = flush | ~(load_use_stall | ex_stall);
  assign ifid_write = flush | ~(load_use_stall | ex_stall);

  assign load_bubble  = flush | (~ex_stall & (load_use_stall | ~id_valid));
  assign load_instr   = ~flush & ~ex_stall & ~load_use_stall & id_valid;
  assign count_hazard = ~flush & ~ex_stall & load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_funct30  <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_ALUop    <= 2'b00;
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_funct30  <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_ALUop    <= 2'b00;
    end else if (load_instr) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct30  <= id_funct30;
      ex_RegWrite <= RegWrite;
      ex_MemtoReg <= MemtoReg;
      ex_MemRead  <= MemRead;
      ex_MemWrite <= MemWrite;
      ex_ALUSrc   <= ALUSrc;
      ex_Branch   <= Branch;
      ex_ALUop    <= ALUop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_cnt <= 16'd0;
    end else if (count_hazard && (hazard_cnt != 16'hFFFF)) begin
      hazard_cnt <= hazard_cnt + 16'd1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1 (asynchronous, active-high).
REQ-002 SHALL have these ID-side inputs:
- id_valid, 1: decode slot holds a real instruction.
- id_pc, 32: instruction PC.
- id_rs1_data, id_rs2_data, 32: register-file read data.
- id_imm, 32: sign-extended immediate.
- id_rs1, id_rs2, id_rd, 5 each: register indices.
- id_funct3, 3; id_funct30, 1: instr[30].
REQ-003 SHALL have decoder control inputs, 1 bit each unless noted: RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUop (2).
REQ-004 SHALL have EX-side control inputs: flush, 1 (branch resolved taken, kill EX contents); ex_stall, 1 (downstream not ready, hold EX contents).
REQ-005 SHALL have registered outputs ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct30, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_Branch, ex_ALUop, with widths matching their ID/decoder sources.
REQ-006 SHALL have combinational outputs pc_write, 1, and ifid_write, 1, as upstream hold enables, plus load_use_stall, 1.
REQ-007 SHALL have registered output hazard_cnt, 16: count of inserted load-use bubbles.

Function
REQ-008 load_use_stall SHALL equal ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)); the rs2 compare is unconditional.
REQ-009 pc_write and ifid_write SHALL both equal ~(load_use_stall | ex_stall) when flush = 0, and SHALL both be 1 when flush = 1.
REQ-010 A bubble SHALL be defined as ex_valid = 0, all ex_* control outputs = 0, ex_ALUop = 2'b00, and all data and index outputs = 0.
REQ-011 EX register update priority at each rising edge SHALL be:
- flush: load bubble.
- else ex_stall: hold all ex_* values.
- else load_use_stall: load bubble.
- else id_valid = 0: load bubble.
- else: load all id_* and control inputs, with ex_valid = 1.
REQ-012 The latency from ID inputs to ex_* outputs SHALL be exactly one cycle when no stall, flush or hazard is present.
REQ-013 The stall SHALL last exactly one cycle per load-use pair; on the following cycle the bubble in EX clears the hazard and the held instruction loads.
REQ-014 hazard_cnt SHALL increment by 1 on each edge where a bubble is loaded by the load_use_stall branch of REQ-011.
REQ-015 hazard_cnt SHALL NOT increment on edges where flush or ex_stall wins.
REQ-016 hazard_cnt SHALL saturate at 16'hFFFF without wrapping.
REQ-017 When flush and load_use_stall are asserted in the same cycle, flush SHALL win and hazard_cnt SHALL NOT increment.
REQ-018 When ex_stall and load_use_stall are asserted in the same cycle, EX SHALL hold, hazard_cnt SHALL NOT increment, and the hazard SHALL be re-evaluated the next cycle.
REQ-019 Destination x0 (ex_rd == 0) SHALL never create a load-use stall.

Reset
REQ-020 While rst = 1, all ex_* outputs SHALL be the bubble of REQ-010 and hazard_cnt SHALL be 0, immediately and independent of clk.
REQ-021 Assertion of rst mid-stall SHALL discard the held EX contents; after release, load_use_stall SHALL be 0 until a new load enters EX.
REQ-022 The first rising edge after rst deasserts SHALL follow REQ-011 normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- R-type, id_rd = 5, RegWrite = 1, ALUop = 10, id_valid = 1, no hazard -> next cycle ex_valid = 1, ex_rd = 5, ex_ALUop = 10, pc_write = 1.
- Load with rd = 7 in EX, then ID instruction with rs2 = 7 -> load_use_stall = 1, pc_write = 0, ifid_write = 0 for one cycle; EX shows a bubble; hazard_cnt 0 -> 1; the held instruction reaches EX one cycle later.
- Load with rd = 0 in EX, ID rs1 = 0 -> load_use_stall = 0, no bubble, hazard_cnt unchanged.
- flush = 1 together with a load-use condition -> EX is a bubble, pc_write = 1, hazard_cnt unchanged.
- ex_stall = 1 for 3 cycles with store data 32'hDEADBEEF in EX -> ex_rs2_data holds DEADBEEF, ex_MemWrite = 1 for all 3 cycles, pc_write = 0.
- hazard_cnt preloaded to FFFF via 65535 hazards, then one more hazard -> count stays FFFF; asynchronous rst pulse mid-cycle -> all outputs 0 before the next edge.
